// File: rtl/bin2oct_digit_serializer_if.sv
// Word-in / octal-digit-out stream bundle for bin2oct_digit_serializer.
// master = the serializer, slave = the word source and digit sink.
interface bin2oct_digit_serializer_if #(
  parameter int WIDTH = 4
);
  localparam int NDIG = (WIDTH + 2) / 3;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             dig_valid;
  logic             dig_ready;
  logic [2:0]       dig_data;
  logic [IW-1:0]    dig_index;
  logic             dig_last;
  logic             busy;

  modport master (
    input  in_valid, in_data, dig_ready,
    output in_ready, dig_valid, dig_data, dig_index, dig_last, busy
  );

  modport slave (
    output in_valid, in_data, dig_ready,
    input  in_ready, dig_valid, dig_data, dig_index, dig_last, busy
  );
endinterface

// File: rtl/bin2oct_digit_serializer.sv
// Binary word to MS-first octal digit stream, back-to-back words without a bubble.
// Optional LEADING_ZERO_SUPPRESS_EN: start each word at its most significant nonzero digit.
//
//   state | meaning
//   IDLE  | no word held, in_ready=1
//   EMIT  | word held, top 3 bits of sr_q presented as the current digit
module bin2oct_digit_serializer #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          nReset,
  bin2oct_digit_serializer_if.master    bus
);
  localparam int NDIG = (WIDTH + 2) / 3;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SRW  = NDIG * 3;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;

  logic [SRW-1:0]   ext;
  logic [SRW-1:0]   sr_load;
  logic [IW-1:0]    idx_load;
  logic             in_ready;
  logic             load;

  assign ext = SRW'(bus.in_data);

  always_comb begin
    sr_load  = ext;
    idx_load = IW'(NDIG - 1);
`ifdef LEADING_ZERO_SUPPRESS_EN
    idx_load = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (ext[3*k +: 3] != 3'd0) idx_load = IW'(k);
    end
    // pre-shift so the first emitted digit sits in the top slot
    sr_load = ext << (3 * (NDIG - 1 - int'(idx_load)));
`endif
  end

  assign in_ready = (state_q == IDLE) | (last_q & bus.dig_ready);
  assign load     = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = EMIT;
      sr_d    = sr_load;
      idx_d   = idx_load;
    end else if (state_q == EMIT && bus.dig_ready) begin
      if (idx_q != '0) begin
        sr_d  = sr_q << 3;
        idx_d = idx_q - IW'(1);
      end else begin
        state_d = IDLE;
      end
    end
    last_d = (state_d == EMIT) && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dig_valid = (state_q == EMIT);
  assign bus.busy      = (state_q == EMIT);
  assign bus.dig_data  = sr_q[SRW-1 -: 3];
  assign bus.dig_index = idx_q;
  assign bus.dig_last  = last_q;
endmodule

// File: tb/tb_bin2oct_digit_serializer.sv
// Scoreboard bench for bin2oct_digit_serializer (WIDTH=4 main instance, WIDTH=12 side instance).
module tb_bin2oct_digit_serializer;
  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  bin2oct_digit_serializer_if #(.WIDTH(4))  bus ();
  bin2oct_digit_serializer_if #(.WIDTH(12)) bus12 ();

  bin2oct_digit_serializer #(.WIDTH(4))  u_dut   (.clk(clk), .nReset(nReset), .bus(bus));
  bin2oct_digit_serializer #(.WIDTH(12)) u_dut12 (.clk(clk), .nReset(nReset), .bus(bus12));

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] sb[$];
  bit   b2b_mode = 0, b2b_started = 0, rand_mode = 0;
  int   gap_cnt = 0;
  bit   hold_v = 0;
  logic [6:0] hold_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected digit stream for one word: {last, index, digit}
  task automatic push_word(input logic [3:0] w);
    int ms;
    logic [3:0] d;
    ms = 1;
`ifdef LEADING_ZERO_SUPPRESS_EN
    ms = 0;
    for (int k = 0; k < 2; k++) if (((w >> (3*k)) & 4'd7) != 0) ms = k;
`endif
    for (int k = ms; k >= 0; k--) begin
      d = (w >> (3*k)) & 4'd7;
      sb.push_back({(k == 0), 3'(k), d[2:0]});
    end
  endtask

  wire [6:0] cur = {bus.dig_last, 3'(bus.dig_index), bus.dig_data};

  always @(negedge clk) begin
    if (!nReset) begin
      hold_v = 0;
    end else begin
      if (hold_v) check("hold_stable", {bus.dig_valid, cur}, {1'b1, hold_val});
      if (bus.dig_valid && bus.dig_ready) begin
        if (sb.size() == 0) check("digit_without_word", 32'(sb.size()), 32'd1);
        else check("digit", cur, sb.pop_front());
      end
      if (b2b_mode) begin
        if (bus.dig_valid) b2b_started = 1;
        else if (b2b_started && sb.size() != 0) gap_cnt++;
      end
      hold_v   = bus.dig_valid && !bus.dig_ready;
      hold_val = cur;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) bus.dig_ready = 1'($urandom_range(0, 1));
  end

  // call just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [3:0] w);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_word(w);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0) done = 1;
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    logic [11:0] w12;
    logic [2:0]  d12;
    bus.in_valid = 0; bus.in_data = '0; bus.dig_ready = 1'b1;
    bus12.in_valid = 0; bus12.in_data = '0; bus12.dig_ready = 1'b1;
    nReset = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dig_valid", bus.dig_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dig_data", bus.dig_data, 0);
    check("rst_dig_last", bus.dig_last, 0);
    @(posedge clk); #1 nReset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    @(posedge clk); #1;
    send(4'hB);
    wait_idle();
    check("idle_after_B", {bus.busy, bus.dig_valid, bus.in_ready}, 3'b001);

    @(posedge clk); #1;
    bus.dig_ready = 1'b0;
    send(4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_data", {bus.dig_valid, bus.dig_data, 3'(bus.dig_index)}, {1'b1, 3'd1, 3'd1});
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.dig_ready = 1'b1;
    wait_idle();

    @(posedge clk); #1;
    b2b_mode = 1; b2b_started = 0; gap_cnt = 0;
    send(4'h9);
    send(4'h2);
    wait_idle();
    check("b2b_gaps", gap_cnt, 0);
    b2b_mode = 0;

    @(posedge clk); #1;
    bus.dig_ready = 1'b0;
    send(4'hB);
    @(negedge clk);
    check("mid_valid", {bus.dig_valid, 3'(bus.dig_index)}, {1'b1, 3'd1});
    #1 nReset = 1'b0;
    #1;
    check("mid_rst", {bus.dig_valid, bus.busy, bus.dig_data, bus.dig_last}, 6'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1; bus.dig_ready = 1'b1;
    send(4'h5);
    wait_idle();

    @(posedge clk); #1;
    send(4'h0);
    wait_idle();

    @(posedge clk); #1;
    rand_mode = 1;
    for (int i = 0; i < 30; i++) begin
      send(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_mode = 0;
    @(posedge clk); #2 bus.dig_ready = 1'b1;
    wait_idle();

    w12 = 12'o7051;
    @(posedge clk); #1;
    bus12.in_valid = 1'b1; bus12.in_data = w12;
    @(posedge clk); #1 bus12.in_valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      d12 = 3'((w12 >> (3*k)) & 12'd7);
      check("w12_digit", {bus12.dig_valid, bus12.dig_last, 2'(bus12.dig_index), bus12.dig_data},
            {1'b1, (k == 0), 2'(k), d12});
    end
    @(negedge clk);
    check("w12_idle", bus12.busy, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
